donut_ray_seq: RTL and testbench
================================

Name: donut_ray_seq

Overview:
- Ray initiator for the donut hit tester.
- Steps camera ray directions across a frame, issues one ray at a time to the tester, waits out the march, and captures hit/light.
- Emits one shaded 8-bit pixel per ray on a valid/ready output.
- Sits between the frame/camera controller and the pixel FIFO/VGA output path.

Parameters:
- H_PIX, 160, pixels per line
- V_PIX, 120, lines per frame
- ITERS, 8, clocks from tester start to valid hit/light
- BG_SHADE, 8'd16, shade emitted on a miss

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  pulse; latch camera params, restart at pixel (0,0)
- run  in  1  permit issuing new rays
- cam_px, cam_py, cam_pz  in  16 each  signed Q8.8 camera origin
- base_rx, base_ry, base_rz  in  16 each  signed ray direction for pixel (0,0)
- step_x  in  16  signed per-pixel increment added to rx
- step_y  in  16  signed per-line increment added to ry
- lx, ly, lz  in  16 each  signed light direction, passed through
- t_start  out  1  one-cycle start pulse to tester
- t_px, t_py, t_pz, t_rx, t_ry, t_rz, t_lx, t_ly, t_lz  out  16 each  tester inputs, valid in the t_start cycle
- t_hit  in  1  tester hit flag
- t_light  in  16  signed tester light, Q8.8
- pix_valid  out  1  shaded pixel available
- pix_ready  in  1  consumer accepts pixel
- pix_shade  out  8  pixel intensity
- pix_col  out  8  column of the current pixel
- pix_row  out  7  row of the current pixel
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset values: all outputs 0; state IDLE; col=0, row=0.
- Reset asserted mid-march aborts immediately; no stale pixel is emitted after release.
- FSM states: IDLE, ISSUE, MARCH, OUT.
- IDLE -> ISSUE when run=1 and the frame is not done.
- ISSUE lasts 1 cycle:
  - t_start=1.
  - t_p* = latched cam_p*, t_r* = current ray registers, t_l* = latched lx/ly/lz.
- MARCH: counter loads ITERS-1 and decrements each cycle. At 0, capture t_hit/t_light and go to OUT.
- Capture timing: capture occurs exactly ITERS cycles after the t_start cycle.
- t_* outputs hold their values through MARCH, but the tester only relies on them in the start cycle.
- OUT: pix_valid=1; pix_shade, pix_col, pix_row stable until pix_ready.
  - On the handshake cycle (valid & ready), advance the pixel.
  - Go to ISSUE if run=1, else IDLE.
- Shade rule:
  - miss -> BG_SHADE.
  - hit and t_light<=0 -> 0.
  - hit and t_light>=255 -> 255.
  - otherwise t_light[7:0].
- Advance rule:
  - If col<H_PIX-1: col+1, rx += step_x.
  - Else at end of line: col=0, rx=base_rx, ry += step_y, row+1.
  - At (H_PIX-1, V_PIX-1): pulse frame_done and go to IDLE. Stay there until the next frame_start.
- Wrap arithmetic: all ray adds are 16-bit two's complement wrap; no saturation.
- frame_start, in any state:
  - Latch cam_p*, base_r*, step_*, l*.
  - rx/ry/rz = base values; col=row=0; state IDLE.
  - pix_valid drops the next cycle; an in-flight ray is discarded.
  - frame_start wins over a simultaneous pix_ready handshake, and no advance occurs.
- Inputs other than at frame_start are not sampled, so they may change freely.

Optional Feature:
- DONUT_DITHER_EN:
  - Defined: 4x4 Bayer offset (0..15, indexed by {row[1:0], col[1:0]}) is added to the hit shade before saturation to 255.
  - Defined: misses are still BG_SHADE.
  - Undefined: shade rule exactly as above.

Decomposition:
- Package donut_pkg:
  - Q8.8 scale constant 256.
  - March start distance 512 and hit limit 2048, for documentation and bench.
  - ITERS default.
  - FSM state enum.
  - Bayer 4x4 table.
- Sub-module ray_stepper: holds rx/ry/rz, col and row.
  - Inputs: load (frame_start), advance (handshake).
  - Outputs: end-of-line and end-of-frame flags.

Test Plan:
- Reset, then frame_start with base_rx=0x0100, step_x=0x0010, run=1, pix_ready=1. Tester model returns hit=1, light=0x0080 -> t_start pulses every ITERS+2 cycles; t_rx sequence 0x0100, 0x0110, 0x0120; pix_shade=0x80.
- Light 0x0190 -> shade 255; light 0xFF00 with hit -> 0; hit=0 -> 16.
- H_PIX=4, V_PIX=2, step_y=0x0020 -> pixel 4 has t_rx=base_rx, t_ry=base_ry+0x20, pix_row=1. frame_done pulses once after pixel 8; no further t_start until frame_start.
- pix_ready low for 5 cycles in OUT -> pix_valid, shade, col and row stable; no new t_start until the accept.
- frame_start at MARCH count 3 -> no pixel emitted for the aborted ray; next t_start carries pixel (0,0).
- rst_n low mid-MARCH -> all outputs 0 asynchronously; after release IDLE, waiting for run.

Source files
------------

// File: rtl/donut_pkg.sv
// donut_pkg: shared constants, FSM state type, Bayer table and the
// shade helper for the donut ray sequencer.
package donut_pkg;

    localparam int Q88_ONE   = 256;
    localparam int MARCH_T0  = 512;
    localparam int HIT_LIMIT = 2048;
    localparam int ITERS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        MARCH,
        OUT
    } seq_state_t;

    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    // Clamp Q8.8 light into 0..255, add dither, saturate at 255.
    function automatic logic [7:0] shade_of(
        input logic              hit,
        input logic signed [15:0] light,
        input logic [7:0]        bg,
        input logic [3:0]        dith
    );
        logic [7:0] base;
        logic [8:0] sum;
        if (light <= 16'sd0)
            base = 8'd0;
        else if (light >= 16'sd255)
            base = 8'd255;
        else
            base = light[7:0];
        sum = {1'b0, base} + {5'd0, dith};
        if (!hit)
            shade_of = bg;
        else if (sum[8])
            shade_of = 8'd255;
        else
            shade_of = sum[7:0];
    endfunction

endpackage

// File: rtl/donut_ray_seq_if.sv
// donut_ray_seq_if: tester start/operand/result bus plus the shaded pixel
// valid/ready output. master = sequencer, slave = tester + pixel consumer.
interface donut_ray_seq_if;

    logic        t_start;
    logic [15:0] t_px, t_py, t_pz;
    logic [15:0] t_rx, t_ry, t_rz;
    logic [15:0] t_lx, t_ly, t_lz;
    logic        t_hit;
    logic [15:0] t_light;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_shade;
    logic [7:0]  pix_col;
    logic [6:0]  pix_row;
    logic        frame_done;

    modport master (
        output t_start,
        output t_px, t_py, t_pz, t_rx, t_ry, t_rz, t_lx, t_ly, t_lz,
        input  t_hit, t_light,
        output pix_valid, pix_shade, pix_col, pix_row, frame_done,
        input  pix_ready
    );

    modport slave (
        input  t_start,
        input  t_px, t_py, t_pz, t_rx, t_ry, t_rz, t_lx, t_ly, t_lz,
        output t_hit, t_light,
        input  pix_valid, pix_shade, pix_col, pix_row, frame_done,
        output pix_ready
    );

endinterface

// File: rtl/donut_ray_seq_ray_stepper.sv
// ray_stepper: ray direction registers and pixel position for the frame.
// Ports: load (frame_start), advance (pixel accepted) -> rx/ry/rz, col, row, eol, eof.
module ray_stepper #(
    parameter int H_PIX = 160,
    parameter int V_PIX = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] base_rx,
    input  logic [15:0] base_ry,
    input  logic [15:0] base_rz,
    input  logic [15:0] step_x,
    input  logic [15:0] step_y,
    output logic [15:0] rx,
    output logic [15:0] ry,
    output logic [15:0] rz,
    output logic [7:0]  col,
    output logic [6:0]  row,
    output logic        eol,
    output logic        eof
);

    logic [15:0] brx, sx, sy;

    assign eol = (col == 8'(H_PIX - 1));
    assign eof = eol && (row == 7'(V_PIX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brx <= '0;
            sx  <= '0;
            sy  <= '0;
            rx  <= '0;
            ry  <= '0;
            rz  <= '0;
            col <= '0;
            row <= '0;
        end else if (load) begin
            brx <= base_rx;
            sx  <= step_x;
            sy  <= step_y;
            rx  <= base_rx;
            ry  <= base_ry;
            rz  <= base_rz;
            col <= '0;
            row <= '0;
        end else if (advance && !eof) begin
            if (eol) begin
                col <= '0;
                rx  <= brx;
                ry  <= ry + sy;
                row <= row + 7'd1;
            end else begin
                col <= col + 8'd1;
                rx  <= rx + sx;
            end
        end
    end

endmodule

// File: rtl/donut_ray_seq.sv
// donut_ray_seq: issues one camera ray per pixel to the hit tester, waits
// ITERS clocks, shades the result onto a valid/ready pixel port.
// Ports: clk, rst_n, frame_start, run, cam/base/step/light params, bus (master).
// Optional: DONUT_DITHER_EN adds a 4x4 Bayer offset to hit shades.
module donut_ray_seq
    import donut_pkg::*;
#(
    parameter int         H_PIX    = 160,
    parameter int         V_PIX    = 120,
    parameter int         ITERS    = ITERS_DEF,
    parameter logic [7:0] BG_SHADE = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        run,
    input  logic [15:0] cam_px,
    input  logic [15:0] cam_py,
    input  logic [15:0] cam_pz,
    input  logic [15:0] base_rx,
    input  logic [15:0] base_ry,
    input  logic [15:0] base_rz,
    input  logic [15:0] step_x,
    input  logic [15:0] step_y,
    input  logic [15:0] lx,
    input  logic [15:0] ly,
    input  logic [15:0] lz,
    donut_ray_seq_if.master bus
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    seq_state_t  state;
    logic [CW-1:0] cnt;
    logic        done;
    logic [15:0] px_q, py_q, pz_q;
    logic [15:0] lx_q, ly_q, lz_q;
    logic [15:0] rx, ry, rz;
    logic [7:0]  col;
    logic [6:0]  row;
    logic        eol, eof, last_pix;
    logic        adv;
    logic [3:0]  dith;

    // frame_start beats a same-cycle handshake: no advance.
    assign adv      = (state == OUT) && bus.pix_ready && !frame_start;
    assign last_pix = eol && eof;

`ifdef DONUT_DITHER_EN
    assign dith = BAYER[{row[1:0], col[1:0]}];
`else
    assign dith = 4'd0;
`endif

    ray_stepper #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX)
    ) u_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (frame_start),
        .advance (adv),
        .base_rx (base_rx),
        .base_ry (base_ry),
        .base_rz (base_rz),
        .step_x  (step_x),
        .step_y  (step_y),
        .rx      (rx),
        .ry      (ry),
        .rz      (rz),
        .col     (col),
        .row     (row),
        .eol     (eol),
        .eof     (eof)
    );

    // Operands come straight from latched/stepper registers and stay put
    // through MARCH; they only move on frame_start or an accepted pixel.
    assign bus.t_px    = px_q;
    assign bus.t_py    = py_q;
    assign bus.t_pz    = pz_q;
    assign bus.t_rx    = rx;
    assign bus.t_ry    = ry;
    assign bus.t_rz    = rz;
    assign bus.t_lx    = lx_q;
    assign bus.t_ly    = ly_q;
    assign bus.t_lz    = lz_q;
    assign bus.pix_col = col;
    assign bus.pix_row = row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            done           <= 1'b0;
            px_q           <= '0;
            py_q           <= '0;
            pz_q           <= '0;
            lx_q           <= '0;
            ly_q           <= '0;
            lz_q           <= '0;
            bus.t_start    <= 1'b0;
            bus.pix_valid  <= 1'b0;
            bus.pix_shade  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.t_start    <= 1'b0;
            bus.frame_done <= 1'b0;
            if (frame_start) begin
                px_q          <= cam_px;
                py_q          <= cam_py;
                pz_q          <= cam_pz;
                lx_q          <= lx;
                ly_q          <= ly;
                lz_q          <= lz;
                done          <= 1'b0;
                state         <= IDLE;
                bus.pix_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (run && !done) begin
                            state       <= ISSUE;
                            bus.t_start <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        state <= MARCH;
                        cnt   <= CW'(ITERS - 1);
                    end
                    MARCH: begin
                        if (cnt == '0) begin
                            bus.pix_shade <= shade_of(bus.t_hit, bus.t_light,
                                                      BG_SHADE, dith);
                            bus.pix_valid <= 1'b1;
                            state         <= OUT;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    OUT: begin
                        if (bus.pix_ready) begin
                            bus.pix_valid <= 1'b0;
                            if (last_pix) begin
                                done           <= 1'b1;
                                bus.frame_done <= 1'b1;
                                state          <= IDLE;
                            end else if (run) begin
                                state       <= ISSUE;
                                bus.t_start <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_donut_ray_seq.sv
// tb_donut_ray_seq: directed bench with a tester model and a pixel
// scoreboard for donut_ray_seq on a 4x2 frame.
module tb_donut_ray_seq;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int IT = 8;
`ifdef DONUT_DITHER_EN
    localparam bit DITH = 1'b1;
`else
    localparam bit DITH = 1'b0;
`endif

    localparam logic [15:0] LT [8] = '{16'h0080, 16'h0190, 16'hFF00, 16'h1234,
                                       16'h00FF, 16'h0000, 16'h0001, 16'h00FE};
    localparam bit HT [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam int BAYER_TB [16] = '{0, 8, 2, 10, 12, 4, 14, 6,
                                     3, 11, 1, 9, 15, 7, 13, 5};

    typedef struct {
        logic [7:0] shade;
        int         col;
        int         row;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        run;
    logic [15:0] cam_px, cam_py, cam_pz;
    logic [15:0] base_rx, base_ry, base_rz;
    logic [15:0] step_x, step_y;
    logic [15:0] lx, ly, lz;

    donut_ray_seq_if bus ();

    donut_ray_seq #(
        .H_PIX    (H),
        .V_PIX    (V),
        .ITERS    (IT),
        .BG_SHADE (8'd16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .run         (run),
        .cam_px      (cam_px),
        .cam_py      (cam_py),
        .cam_pz      (cam_pz),
        .base_rx     (base_rx),
        .base_ry     (base_ry),
        .base_rz     (base_rz),
        .step_x      (step_x),
        .step_y      (step_y),
        .lx          (lx),
        .ly          (ly),
        .lz          (lz),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ts = 0;
    int   n_acc = 0;
    int   n_fd = 0;
    int   cyc = 0;
    int   last_ts = -1;
    int   k = -1;
    int   mcol = 0;
    int   mrow = 0;
    bit   fd_exp = 1'b0;
    bit   chk_period = 1'b0;
    bit   ph = 1'b0;
    logic [15:0] pl = '0;
    exp_t q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_shade(input bit h, input logic [15:0] l,
                                             input int c, input int r);
        int v;
        if (!h) return 8'd16;
        v = int'($signed(l));
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        if (DITH) v = v + BAYER_TB[(r % 4) * 4 + (c % 4)];
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic fstart();
        frame_start = 1'b1;
        q.delete();
        mcol = 0;
        mrow = 0;
        last_ts = -1;
        fd_exp = 1'b0;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_acc(input int n);
        int t = 0;
        while (n_acc < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", 32'(n_acc >= n), 32'd1);
    endtask

    task automatic wait_ts();
        int t = 0;
        while (!bus.t_start && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t_start_wait", 32'(bus.t_start), 32'd1);
    endtask

    // Tester model + scoreboard monitor, sampling on the falling edge.
    initial begin
        int   idx;
        exp_t e;
        logic [15:0] erx, ery;
        bus.t_hit   = 1'b0;
        bus.t_light = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (fd_exp || bus.frame_done)
                    check("frame_done", 32'(bus.frame_done), 32'(fd_exp));
                if (bus.frame_done) n_fd++;
                fd_exp = 1'b0;
                if (bus.pix_valid)
                    check("valid_has_ray", 32'(q.size() != 0), 32'd1);
                if (bus.t_start && !frame_start) begin
                    idx = n_ts % 8;
                    ph  = HT[idx];
                    pl  = LT[idx];
                    k   = IT;
                    erx = 16'(int'(base_rx) + mcol * int'(step_x));
                    ery = 16'(int'(base_ry) + mrow * int'(step_y));
                    check("t_rx", 32'(bus.t_rx), 32'(erx));
                    check("t_ry", 32'(bus.t_ry), 32'(ery));
                    check("t_rz", 32'(bus.t_rz), 32'(base_rz));
                    check("t_px", 32'(bus.t_px), 32'(cam_px));
                    check("t_lz", 32'(bus.t_lz), 32'(lz));
                    if (chk_period && last_ts >= 0)
                        check("t_start_period", 32'(cyc - last_ts), 32'(IT + 2));
                    last_ts = cyc;
                    q.push_back('{exp_shade(ph, pl, mcol, mrow), mcol, mrow});
                    n_ts++;
                end else if (k >= 0) begin
                    k--;
                end
                if (bus.pix_valid && bus.pix_ready && !frame_start
                    && q.size() != 0) begin
                    e = q.pop_front();
                    check("pix_shade", 32'(bus.pix_shade), 32'(e.shade));
                    check("pix_col", 32'(bus.pix_col), 32'(e.col));
                    check("pix_row", 32'(bus.pix_row), 32'(e.row));
                    n_acc++;
                    if (mcol == H - 1) begin
                        mcol = 0;
                        if (mrow == V - 1) fd_exp = 1'b1;
                        else mrow++;
                    end else begin
                        mcol++;
                    end
                end
            end else begin
                k = -1;
            end
            // Result is only genuine in cycle start+ITERS; elsewhere inverted.
            bus.t_hit   = (k == 0) ? ph : !ph;
            bus.t_light = (k == 0) ? pl : ~pl;
        end
    end

    initial begin
        int   a;
        int   s;
        int   t;
        exp_t e0;
        rst_n         = 1'b0;
        frame_start   = 1'b0;
        run           = 1'b0;
        bus.pix_ready = 1'b0;
        cam_px = '0; cam_py = '0; cam_pz = '0;
        base_rx = '0; base_ry = '0; base_rz = '0;
        step_x = '0; step_y = '0;
        lx = '0; ly = '0; lz = '0;

        @(posedge clk);
        #1;
        check("rst_t_start", 32'(bus.t_start), 32'd0);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_t_rx", 32'(bus.t_rx), 32'd0);
        check("rst_shade", 32'(bus.pix_shade), 32'd0);
        check("rst_col", 32'(bus.pix_col), 32'd0);
        check("rst_row", 32'(bus.pix_row), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full frame, consumer always ready.
        cam_px = 16'h1111; cam_py = 16'h2222; cam_pz = 16'h3333;
        base_rx = 16'h0100; base_ry = 16'h0200; base_rz = 16'h0300;
        step_x = 16'h0010; step_y = 16'h0020;
        lx = 16'h0A0A; ly = 16'h0B0B; lz = 16'h0C0C;
        run = 1'b1;
        bus.pix_ready = 1'b1;
        chk_period = 1'b1;
        @(posedge clk);
        #1;
        fstart();
        wait_acc(8);
        repeat (30) @(negedge clk);
        check("frame1_rays", 32'(n_ts), 32'd8);
        check("frame1_done_count", 32'(n_fd), 32'd1);
        check("idle_after_frame", 32'(bus.pix_valid), 32'd0);

        // Back-pressure: pixel held stable while ready is low.
        chk_period = 1'b0;
        @(posedge clk);
        #1;
        bus.pix_ready = 1'b0;
        fstart();
        t = 0;
        while (!bus.pix_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        e0 = '{8'h00, -1, -1};
        if (q.size() > 0) e0 = q[0];
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus.pix_valid), 32'd1);
            check("stall_shade", 32'(bus.pix_shade), 32'(e0.shade));
            check("stall_col", 32'(bus.pix_col), 32'(e0.col));
            check("stall_row", 32'(bus.pix_row), 32'(e0.row));
            check("stall_no_issue", 32'(n_ts), 32'd9);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.pix_ready = 1'b1;
        a = n_acc;
        wait_acc(a + 2);

        // Abort an in-flight ray at MARCH count 3 with new parameters.
        wait_ts();
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        base_rx = 16'h0400;
        cam_px  = 16'h7777;
        lz      = 16'h0D0D;
        fstart();
        a = n_acc;
        wait_acc(a + 2);

        // Asynchronous reset in the middle of a march.
        wait_ts();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("arst_t_start", 32'(bus.t_start), 32'd0);
        check("arst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("arst_t_rx", 32'(bus.t_rx), 32'd0);
        check("arst_t_px", 32'(bus.t_px), 32'd0);
        check("arst_t_lz", 32'(bus.t_lz), 32'd0);
        check("arst_col", 32'(bus.pix_col), 32'd0);
        check("arst_row", 32'(bus.pix_row), 32'd0);
        q.delete();
        mcol = 0;
        mrow = 0;
        s = n_ts;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("post_rst_no_issue", 32'(n_ts), 32'(s));
        check("post_rst_no_valid", 32'(bus.pix_valid), 32'd0);
        check("total_frame_done", 32'(n_fd), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
